// File: rtl/axi4_modport_pkg.sv
// Shared constants for the axi4_modport passive protocol monitor.
package axi4_modport_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  // Bit positions inside stab_err
  localparam int CH_AW  = 0;
  localparam int CH_W   = 1;
  localparam int CH_B   = 2;
  localparam int CH_AR  = 3;
  localparam int CH_R   = 4;
  localparam int NUM_CH = 5;

  function automatic logic is_err_resp(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi4_chan_checker.sv
// Per-channel handshake/last counters and valid/payload stability checker.
module axi4_chan_checker #(
  parameter int PAYLOAD_WIDTH = 8,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     clr,
  input  logic                     valid,
  input  logic                     ready,
  input  logic                     last,
  input  logic [PAYLOAD_WIDTH-1:0] payload,
  output logic [COUNT_WIDTH-1:0]   hs_cnt,
  output logic [COUNT_WIDTH-1:0]   last_cnt,
  output logic                     stab_err
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic                     stalled_q;
  logic [PAYLOAD_WIDTH-1:0] payload_q;
  logic                     hs;
  logic                     stall;
  logic                     violation;

  assign hs    = valid & ready;
  assign stall = valid & ~ready;
  // ~valid short-circuits the compare so X payload on a dropped valid still flags
  assign violation = stalled_q & (~valid | (payload != payload_q));

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      stalled_q <= 1'b0;
      payload_q <= '0;
      hs_cnt    <= '0;
      last_cnt  <= '0;
      stab_err  <= 1'b0;
    end else if (clr) begin
      stalled_q <= 1'b0;
      payload_q <= '0;
      hs_cnt    <= '0;
      last_cnt  <= '0;
      stab_err  <= 1'b0;
    end else begin
      stalled_q <= stall;
      if (stall)
        payload_q <= payload;
      if (hs)
        hs_cnt <= hs_cnt + CNT_ONE;
      if (hs && last)
        last_cnt <= last_cnt + CNT_ONE;
      if (violation)
        stab_err <= 1'b1;
    end
  end

endmodule

// File: rtl/axi4_modport.sv
// Passive AXI4 monitor: counts handshakes on all five channels and raises
// sticky stability and error-response flags. Drives nothing on the bus.
module axi4_modport #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic                   clr,
  input  logic                   aw_valid,
  input  logic                   aw_ready,
  input  logic [ID_WIDTH-1:0]    aw_id,
  input  logic [ADDR_WIDTH-1:0]  aw_addr,
  input  logic [7:0]             aw_len,
  input  logic [2:0]             aw_size,
  input  logic [1:0]             aw_burst,
  input  logic [3:0]             aw_cache,
  input  logic [2:0]             aw_prot,
  input  logic [3:0]             aw_qos,
  input  logic [3:0]             aw_region,
  input  logic                   w_valid,
  input  logic                   w_ready,
  input  logic                   w_last,
  input  logic [DATA_WIDTH-1:0]  w_data,
  input  logic [STRB_WIDTH-1:0]  w_strb,
  input  logic                   b_valid,
  input  logic                   b_ready,
  input  logic [ID_WIDTH-1:0]    b_id,
  input  logic [1:0]             b_resp,
  input  logic                   ar_valid,
  input  logic                   ar_ready,
  input  logic [ID_WIDTH-1:0]    ar_id,
  input  logic [ADDR_WIDTH-1:0]  ar_addr,
  input  logic [7:0]             ar_len,
  input  logic [2:0]             ar_size,
  input  logic [1:0]             ar_burst,
  input  logic [3:0]             ar_cache,
  input  logic [2:0]             ar_prot,
  input  logic [3:0]             ar_qos,
  input  logic [3:0]             ar_region,
  input  logic                   r_valid,
  input  logic                   r_ready,
  input  logic                   r_last,
  input  logic [ID_WIDTH-1:0]    r_id,
  input  logic [DATA_WIDTH-1:0]  r_data,
  input  logic [1:0]             r_resp,
  output logic [COUNT_WIDTH-1:0] aw_cnt,
  output logic [COUNT_WIDTH-1:0] w_cnt,
  output logic [COUNT_WIDTH-1:0] w_last_cnt,
  output logic [COUNT_WIDTH-1:0] b_cnt,
  output logic [COUNT_WIDTH-1:0] ar_cnt,
  output logic [COUNT_WIDTH-1:0] r_cnt,
  output logic [COUNT_WIDTH-1:0] r_last_cnt,
  output logic [4:0]             stab_err,
  output logic [1:0]             resp_err,
  output logic                   any_err
);

  import axi4_modport_pkg::*;

  localparam int AX_PW = ID_WIDTH + ADDR_WIDTH + 28;
  localparam int W_PW  = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int B_PW  = ID_WIDTH + 2;
  localparam int R_PW  = ID_WIDTH + DATA_WIDTH + 3;

  logic [AX_PW-1:0] aw_payload;
  logic [AX_PW-1:0] ar_payload;
  logic [W_PW-1:0]  w_payload;
  logic [B_PW-1:0]  b_payload;
  logic [R_PW-1:0]  r_payload;

  // Address, write-response channels have no last beat; their last counters go unused
  logic [COUNT_WIDTH-1:0] unused_aw_last;
  logic [COUNT_WIDTH-1:0] unused_b_last;
  logic [COUNT_WIDTH-1:0] unused_ar_last;

  assign aw_payload = {aw_id, aw_addr, aw_len, aw_size, aw_burst,
                       aw_cache, aw_prot, aw_qos, aw_region};
  assign ar_payload = {ar_id, ar_addr, ar_len, ar_size, ar_burst,
                       ar_cache, ar_prot, ar_qos, ar_region};
  assign w_payload  = {w_data, w_strb, w_last};
  assign b_payload  = {b_id, b_resp};
  assign r_payload  = {r_id, r_data, r_resp, r_last};

  axi4_chan_checker #(.PAYLOAD_WIDTH(AX_PW), .COUNT_WIDTH(COUNT_WIDTH)) u_aw (
    .aclk(aclk), .areset_n(areset_n), .clr(clr),
    .valid(aw_valid), .ready(aw_ready), .last(1'b0), .payload(aw_payload),
    .hs_cnt(aw_cnt), .last_cnt(unused_aw_last), .stab_err(stab_err[CH_AW])
  );

  axi4_chan_checker #(.PAYLOAD_WIDTH(W_PW), .COUNT_WIDTH(COUNT_WIDTH)) u_w (
    .aclk(aclk), .areset_n(areset_n), .clr(clr),
    .valid(w_valid), .ready(w_ready), .last(w_last), .payload(w_payload),
    .hs_cnt(w_cnt), .last_cnt(w_last_cnt), .stab_err(stab_err[CH_W])
  );

  axi4_chan_checker #(.PAYLOAD_WIDTH(B_PW), .COUNT_WIDTH(COUNT_WIDTH)) u_b (
    .aclk(aclk), .areset_n(areset_n), .clr(clr),
    .valid(b_valid), .ready(b_ready), .last(1'b0), .payload(b_payload),
    .hs_cnt(b_cnt), .last_cnt(unused_b_last), .stab_err(stab_err[CH_B])
  );

  axi4_chan_checker #(.PAYLOAD_WIDTH(AX_PW), .COUNT_WIDTH(COUNT_WIDTH)) u_ar (
    .aclk(aclk), .areset_n(areset_n), .clr(clr),
    .valid(ar_valid), .ready(ar_ready), .last(1'b0), .payload(ar_payload),
    .hs_cnt(ar_cnt), .last_cnt(unused_ar_last), .stab_err(stab_err[CH_AR])
  );

  axi4_chan_checker #(.PAYLOAD_WIDTH(R_PW), .COUNT_WIDTH(COUNT_WIDTH)) u_r (
    .aclk(aclk), .areset_n(areset_n), .clr(clr),
    .valid(r_valid), .ready(r_ready), .last(r_last), .payload(r_payload),
    .hs_cnt(r_cnt), .last_cnt(r_last_cnt), .stab_err(stab_err[CH_R])
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      resp_err <= '0;
    end else if (clr) begin
      resp_err <= '0;
    end else begin
      if (b_valid && b_ready && is_err_resp(b_resp))
        resp_err[0] <= 1'b1;
      if (r_valid && r_ready && is_err_resp(r_resp))
        resp_err[1] <= 1'b1;
    end
  end

  assign any_err = (|stab_err) | (|resp_err);

endmodule

// File: tb/tb_axi4_modport.sv
// Directed bench for axi4_modport with a queue-based scoreboard and a
// negedge monitor that compares registered outputs against expectations.
module tb_axi4_modport;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int CW  = 32;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          clr;
  logic          aw_valid, aw_ready;
  logic [IDW-1:0] aw_id;
  logic [AW-1:0] aw_addr;
  logic [7:0]    aw_len;
  logic [2:0]    aw_size;
  logic [1:0]    aw_burst;
  logic [3:0]    aw_cache;
  logic [2:0]    aw_prot;
  logic [3:0]    aw_qos;
  logic [3:0]    aw_region;
  logic          w_valid, w_ready, w_last;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          b_valid, b_ready;
  logic [IDW-1:0] b_id;
  logic [1:0]    b_resp;
  logic          ar_valid, ar_ready;
  logic [IDW-1:0] ar_id;
  logic [AW-1:0] ar_addr;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [1:0]    ar_burst;
  logic [3:0]    ar_cache;
  logic [2:0]    ar_prot;
  logic [3:0]    ar_qos;
  logic [3:0]    ar_region;
  logic          r_valid, r_ready, r_last;
  logic [IDW-1:0] r_id;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;

  logic [CW-1:0] aw_cnt, w_cnt, w_last_cnt, b_cnt, ar_cnt, r_cnt, r_last_cnt;
  logic [4:0]    stab_err;
  logic [1:0]    resp_err;
  logic          any_err;

  logic [3:0]    c4_aw_cnt, c4_w_cnt, c4_w_last_cnt, c4_b_cnt, c4_ar_cnt, c4_r_cnt, c4_r_last_cnt;
  logic [4:0]    c4_stab_err;
  logic [1:0]    c4_resp_err;
  logic          c4_any_err;

  always #5 aclk = ~aclk;

  axi4_modport dut (
    .aclk(aclk), .areset_n(areset_n), .clr(clr),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_cache(aw_cache),
    .aw_prot(aw_prot), .aw_qos(aw_qos), .aw_region(aw_region),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
    .ar_prot(ar_prot), .ar_qos(ar_qos), .ar_region(ar_region),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp),
    .aw_cnt(aw_cnt), .w_cnt(w_cnt), .w_last_cnt(w_last_cnt), .b_cnt(b_cnt),
    .ar_cnt(ar_cnt), .r_cnt(r_cnt), .r_last_cnt(r_last_cnt),
    .stab_err(stab_err), .resp_err(resp_err), .any_err(any_err)
  );

  axi4_modport #(.COUNT_WIDTH(4)) dut4 (
    .aclk(aclk), .areset_n(areset_n), .clr(clr),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_cache(aw_cache),
    .aw_prot(aw_prot), .aw_qos(aw_qos), .aw_region(aw_region),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
    .ar_prot(ar_prot), .ar_qos(ar_qos), .ar_region(ar_region),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp),
    .aw_cnt(c4_aw_cnt), .w_cnt(c4_w_cnt), .w_last_cnt(c4_w_last_cnt), .b_cnt(c4_b_cnt),
    .ar_cnt(c4_ar_cnt), .r_cnt(c4_r_cnt), .r_last_cnt(c4_r_last_cnt),
    .stab_err(c4_stab_err), .resp_err(c4_resp_err), .any_err(c4_any_err)
  );

  localparam int S_AW = 0, S_W = 1, S_WL = 2, S_B = 3, S_AR = 4, S_R = 5, S_RL = 6;
  localparam int S_STAB = 7, S_RESP = 8, S_ANY = 9, S_B4 = 10;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_AW:   return aw_cnt;
      S_W:    return w_cnt;
      S_WL:   return w_last_cnt;
      S_B:    return b_cnt;
      S_AR:   return ar_cnt;
      S_R:    return r_cnt;
      S_RL:   return r_last_cnt;
      S_STAB: return {27'd0, stab_err};
      S_RESP: return {30'd0, resp_err};
      S_ANY:  return {31'd0, any_err};
      S_B4:   return {28'd0, c4_b_cnt};
      default: return '1;
    endcase
  endfunction

  task automatic expect_v(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  // Monitor: drains expectations half a cycle after each stimulus edge
  always @(negedge aclk) begin
    while (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = actual(mon_e.sel);
      n_tests++;
      if (mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", mon_e.name, mon_act, mon_e.val);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_all();
    clr = 1'b0;
    aw_valid = 1'b0; aw_ready = 1'b0; aw_id = '0; aw_addr = '0; aw_len = '0;
    aw_size = '0; aw_burst = 2'd1; aw_cache = '0; aw_prot = '0; aw_qos = '0; aw_region = '0;
    w_valid = 1'b0; w_ready = 1'b0; w_last = 1'b0; w_data = '0; w_strb = '1;
    b_valid = 1'b0; b_ready = 1'b0; b_id = '0; b_resp = '0;
    ar_valid = 1'b0; ar_ready = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0;
    ar_size = '0; ar_burst = 2'd1; ar_cache = '0; ar_prot = '0; ar_qos = '0; ar_region = '0;
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; r_id = '0; r_data = '0; r_resp = '0;
  endtask

  initial begin
    areset_n = 1'b0;
    idle_all();
    repeat (2) tick();
    expect_v("rst_aw_cnt", S_AW, 0);
    expect_v("rst_stab", S_STAB, 0);
    expect_v("rst_resp", S_RESP, 0);
    expect_v("rst_any", S_ANY, 0);
    @(negedge aclk);
    #2 areset_n = 1'b1;

    // Three back-to-back AW handshakes
    aw_valid = 1'b1; aw_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      aw_id = 4'(i); aw_addr = 32'h100 * (i + 1);
      tick();
    end
    aw_valid = 1'b0; aw_ready = 1'b0;
    expect_v("aw_cnt_3", S_AW, 3);
    expect_v("aw_stab", S_STAB, 0);
    expect_v("aw_any", S_ANY, 0);

    // W stalled four cycles with stable payload, then accepted
    w_valid = 1'b1; w_ready = 1'b0; w_data = 64'hDEAD_BEEF; w_last = 1'b1;
    repeat (4) tick();
    expect_v("w_stall_cnt", S_W, 0);
    expect_v("w_stall_stab", S_STAB, 0);
    w_ready = 1'b1;
    tick();
    w_valid = 1'b0; w_ready = 1'b0; w_last = 1'b0;
    expect_v("w_cnt_1", S_W, 1);
    expect_v("w_last_cnt_1", S_WL, 1);
    tick();
    expect_v("w_stab_clean", S_STAB, 0);

    // AR stall with address changing mid-stall
    ar_valid = 1'b1; ar_ready = 1'b0; ar_addr = 32'h1000;
    tick();
    expect_v("ar_pre_viol", S_STAB, 0);
    ar_addr = 32'h1004;
    tick();
    expect_v("ar_viol", S_STAB, 5'b01000);
    expect_v("ar_viol_any", S_ANY, 1);
    ar_ready = 1'b1;
    tick();
    ar_valid = 1'b0; ar_ready = 1'b0;
    expect_v("ar_cnt_1", S_AR, 1);
    repeat (3) tick();
    expect_v("ar_sticky", S_STAB, 5'b01000);

    // R stall with valid withdrawn
    r_valid = 1'b1; r_ready = 1'b0; r_data = 64'h1234; r_id = 4'h3;
    tick();
    r_valid = 1'b0;
    tick();
    expect_v("r_drop_viol", S_STAB, 5'b11000);

    // B SLVERR, then R EXOKAY with last
    b_valid = 1'b1; b_ready = 1'b1; b_resp = 2'd2;
    tick();
    b_valid = 1'b0; b_ready = 1'b0; b_resp = 2'd0;
    expect_v("b_slverr", S_RESP, 2'b01);
    expect_v("b_cnt_1", S_B, 1);
    expect_v("b4_cnt_1", S_B4, 1);
    r_valid = 1'b1; r_ready = 1'b1; r_resp = 2'd1; r_last = 1'b1;
    tick();
    r_valid = 1'b0; r_ready = 1'b0; r_resp = 2'd0; r_last = 1'b0;
    expect_v("r_exokay", S_RESP, 2'b01);
    expect_v("r_cnt_1", S_R, 1);
    expect_v("r_last_cnt_1", S_RL, 1);

    // Synchronous clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    expect_v("clr_stab", S_STAB, 0);
    expect_v("clr_resp", S_RESP, 0);
    expect_v("clr_any", S_ANY, 0);
    expect_v("clr_aw_cnt", S_AW, 0);
    expect_v("clr_b_cnt", S_B, 0);

    // 17 B handshakes: 4-bit counter wraps to 1
    b_valid = 1'b1; b_ready = 1'b1;
    repeat (17) tick();
    expect_v("b_cnt_17", S_B, 17);
    expect_v("b4_wrap", S_B4, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0; b_valid = 1'b0; b_ready = 1'b0;
    expect_v("clr_over_hs", S_B, 0);
    expect_v("clr_over_hs4", S_B4, 0);

    // Build up state, then reset asynchronously mid-stall
    aw_valid = 1'b1; aw_ready = 1'b1;
    tick();
    aw_valid = 1'b0; aw_ready = 1'b0;
    ar_valid = 1'b1; ar_ready = 1'b0; ar_addr = 32'h2000;
    tick();
    ar_valid = 1'b0;
    tick();
    expect_v("pre_rst_aw", S_AW, 1);
    expect_v("pre_rst_stab", S_STAB, 5'b01000);
    w_valid = 1'b1; w_ready = 1'b0; w_data = 64'h1;
    tick();
    #2 areset_n = 1'b0;
    #1;
    expect_v("async_aw", S_AW, 0);
    expect_v("async_stab", S_STAB, 0);
    expect_v("async_any", S_ANY, 0);
    @(negedge aclk);
    #2 areset_n = 1'b1;
    w_data = 64'h2;
    tick();
    expect_v("post_rst_noflag", S_STAB, 0);
    w_valid = 1'b0;
    tick();
    expect_v("post_rst_detect", S_STAB, 5'b00010);
    idle_all();

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge aclk);
    #1;
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
